// File: rtl/alu_operand_stage.sv
// ID/EX operand stage feeding the 32-bit ALU: one held instruction, RAW hazard handling.
// Define ALU_OPERAND_FORWARDING_EN to forward from EX/MEM and MEM/WB; otherwise hazards stall.
module alu_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_alu_op,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rt_addr,
  input  logic [DATA_WIDTH-1:0]     in_rs_data,
  input  logic [DATA_WIDTH-1:0]     in_rt_data,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic                      in_alu_src,
  input  logic [4:0]                in_shamt,
  input  logic [REG_ADDR_WIDTH-1:0] in_write_reg,
  input  logic                      in_reg_write,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_write_reg,
  input  logic [DATA_WIDTH-1:0]     exmem_data,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_write_reg,
  input  logic [DATA_WIDTH-1:0]     memwb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3:0]                out_alu_op,
  output logic [DATA_WIDTH-1:0]     out_a,
  output logic [DATA_WIDTH-1:0]     out_b,
  output logic [4:0]                out_shamt,
  output logic [REG_ADDR_WIDTH-1:0] out_write_reg,
  output logic                      out_reg_write
);

  // Handshake: a beat moves on a side in any cycle where its valid and ready are both 1.
  // out_valid never drops without a transfer or flush/reset; held fields stay stable meanwhile.

  logic                      valid_q;
  logic [3:0]                alu_op_q;
  logic [REG_ADDR_WIDTH-1:0] rs_addr_q;
  logic [REG_ADDR_WIDTH-1:0] rt_addr_q;
  logic [DATA_WIDTH-1:0]     rs_data_q;
  logic [DATA_WIDTH-1:0]     rt_data_q;
  logic [DATA_WIDTH-1:0]     imm_q;
  logic                      alu_src_q;
  logic [4:0]                shamt_q;
  logic [REG_ADDR_WIDTH-1:0] write_reg_q;
  logic                      reg_write_q;

  logic [DATA_WIDTH-1:0]     rs_fwd;
  logic [DATA_WIDTH-1:0]     rt_fwd;
  logic                      hazard_stall;
  logic                      capture;

  function automatic logic src_match(input logic                      we,
                                     input logic [REG_ADDR_WIDTH-1:0] dst,
                                     input logic [REG_ADDR_WIDTH-1:0] src);
    return we && (dst == src) && (src != '0);
  endfunction

`ifdef ALU_OPERAND_FORWARDING_EN
  // EX/MEM is the younger producer, so it is applied last and wins.
  always_comb begin
    rs_fwd = rs_data_q;
    rt_fwd = rt_data_q;
    if (src_match(memwb_reg_write, memwb_write_reg, rs_addr_q)) rs_fwd = memwb_data;
    if (src_match(exmem_reg_write, exmem_write_reg, rs_addr_q)) rs_fwd = exmem_data;
    if (src_match(memwb_reg_write, memwb_write_reg, rt_addr_q)) rt_fwd = memwb_data;
    if (src_match(exmem_reg_write, exmem_write_reg, rt_addr_q)) rt_fwd = exmem_data;
  end

  assign hazard_stall = 1'b0;
`else
  logic rs_hit;
  logic rt_hit;
  logic unused_fwd_sources;

  always_comb begin
    rs_fwd = rs_data_q;
    rt_fwd = rt_data_q;
  end

  // Write-first register file: once a producer leaves MEM/WB the read data is current.
  always_comb begin
    rs_hit = src_match(valid_q & reg_write_q, write_reg_q, in_rs_addr) ||
             src_match(exmem_reg_write, exmem_write_reg, in_rs_addr) ||
             src_match(memwb_reg_write, memwb_write_reg, in_rs_addr);
    rt_hit = !in_alu_src &&
             (src_match(valid_q & reg_write_q, write_reg_q, in_rt_addr) ||
              src_match(exmem_reg_write, exmem_write_reg, in_rt_addr) ||
              src_match(memwb_reg_write, memwb_write_reg, in_rt_addr));
  end

  assign hazard_stall = in_valid && (rs_hit || rt_hit);
  assign unused_fwd_sources = ^{exmem_data, memwb_data, rs_addr_q, rt_addr_q};
`endif

  assign in_ready = !flush && !hazard_stall && (!valid_q || out_ready);
  assign capture  = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      alu_op_q    <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      shamt_q     <= '0;
      write_reg_q <= '0;
      reg_write_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q     <= 1'b1;
      alu_op_q    <= in_alu_op;
      rs_addr_q   <= in_rs_addr;
      rt_addr_q   <= in_rt_addr;
      rs_data_q   <= in_rs_data;
      rt_data_q   <= in_rt_data;
      imm_q       <= in_imm;
      alu_src_q   <= in_alu_src;
      shamt_q     <= in_shamt;
      write_reg_q <= in_write_reg;
      reg_write_q <= in_reg_write;
    end else begin
      if (valid_q && out_ready) valid_q <= 1'b0;
`ifdef ALU_OPERAND_FORWARDING_EN
      // Latch forwarded values so they survive the producer retiring while we stall.
      if (valid_q) begin
        rs_data_q <= rs_fwd;
        rt_data_q <= rt_fwd;
      end
`endif
    end
  end

  assign out_valid     = valid_q;
  assign out_alu_op    = alu_op_q;
  assign out_a         = rs_fwd;
  assign out_b         = alu_src_q ? imm_q : rt_fwd;
  assign out_shamt     = shamt_q;
  assign out_write_reg = write_reg_q;
  assign out_reg_write = reg_write_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage; forwarding scenarios run when ALU_OPERAND_FORWARDING_EN is defined.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_op;
  logic [4:0]  in_rs_addr, in_rt_addr;
  logic [31:0] in_rs_data, in_rt_data, in_imm;
  logic        in_alu_src;
  logic [4:0]  in_shamt;
  logic [4:0]  in_write_reg;
  logic        in_reg_write;
  logic        exmem_reg_write;
  logic [4:0]  exmem_write_reg;
  logic [31:0] exmem_data;
  logic        memwb_reg_write;
  logic [4:0]  memwb_write_reg;
  logic [31:0] memwb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_op;
  logic [31:0] out_a, out_b;
  logic [4:0]  out_shamt;
  logic [4:0]  out_write_reg;
  logic        out_reg_write;

  int n_checks = 0;
  int n_fail   = 0;

  alu_operand_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_alu_src(in_alu_src), .in_shamt(in_shamt),
    .in_write_reg(in_write_reg), .in_reg_write(in_reg_write),
    .exmem_reg_write(exmem_reg_write), .exmem_write_reg(exmem_write_reg), .exmem_data(exmem_data),
    .memwb_reg_write(memwb_reg_write), .memwb_write_reg(memwb_write_reg), .memwb_data(memwb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_a(out_a), .out_b(out_b), .out_shamt(out_shamt),
    .out_write_reg(out_write_reg), .out_reg_write(out_reg_write)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic drive(input logic [3:0] op, input logic [4:0] rs_a, input logic [4:0] rt_a,
                       input logic [31:0] rs_d, input logic [31:0] rt_d, input logic [31:0] imm,
                       input logic src, input logic [4:0] sh, input logic [4:0] wr, input logic rw);
    in_valid     = 1'b1;
    in_alu_op    = op;
    in_rs_addr   = rs_a;
    in_rt_addr   = rt_a;
    in_rs_data   = rs_d;
    in_rt_data   = rt_d;
    in_imm       = imm;
    in_alu_src   = src;
    in_shamt     = sh;
    in_write_reg = wr;
    in_reg_write = rw;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic clear_producers();
    exmem_reg_write = 1'b0; exmem_write_reg = '0; exmem_data = '0;
    memwb_reg_write = 1'b0; memwb_write_reg = '0; memwb_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(4'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    idle();
    clear_producers();
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({out_valid, out_alu_op, out_a, out_b, out_shamt, out_write_reg, out_reg_write} !== 80'd0) begin
      $display("FAIL reset_outputs: got v=%b op=%h a=%h b=%h sh=%h wr=%h rw=%b, want all 0",
               out_valid, out_alu_op, out_a, out_b, out_shamt, out_write_reg, out_reg_write);
      n_fail++;
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b want 1", in_ready); n_fail++;
    end
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    out_ready = 1'b1;
    drive(4'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, 5'd4, 5'd3, 1'b1);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin $display("FAIL pass_ready: got %b want 1", in_ready); n_fail++; end
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_alu_op, out_a, out_b, out_shamt, out_write_reg, out_reg_write} !==
        {1'b1, 4'd3, 32'd5, 32'd7, 5'd4, 5'd3, 1'b1}) begin
      $display("FAIL pass_rt: got v=%b op=%h a=%h b=%h sh=%h wr=%h rw=%b, want 1 3 5 7 4 3 1",
               out_valid, out_alu_op, out_a, out_b, out_shamt, out_write_reg, out_reg_write);
      n_fail++;
    end
    drive(4'd5, 5'd0, 5'd3, 32'hA, 32'hB, 32'h100, 1'b1, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_alu_op, out_a, out_b} !== {1'b1, 4'd5, 32'hA, 32'h100}) begin
      $display("FAIL pass_imm: got v=%b op=%h a=%h b=%h, want 1 5 a 100",
               out_valid, out_alu_op, out_a, out_b);
      n_fail++;
    end
    idle();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin $display("FAIL pass_drain: out_valid got %b want 0", out_valid); n_fail++; end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(4'd1, 5'd0, 5'd0, 32'h11, 32'h12, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    drive(4'd2, 5'd0, 5'd0, 32'h21, 32'h22, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({in_ready, out_valid, out_alu_op, out_a, out_b} !== {1'b0, 1'b1, 4'd1, 32'h11, 32'h12}) begin
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b op=%h a=%h b=%h, want 0 1 1 11 12",
                 i, in_ready, out_valid, out_alu_op, out_a, out_b);
        n_fail++;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin $display("FAIL bp_release_ready: got %b want 1", in_ready); n_fail++; end
    @(negedge clk);
    idle();
    n_checks++;
    if ({out_valid, out_alu_op, out_a, out_b} !== {1'b1, 4'd2, 32'h21, 32'h22}) begin
      $display("FAIL bp_next: got v=%b op=%h a=%h b=%h, want 1 2 21 22", out_valid, out_alu_op, out_a, out_b);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin $display("FAIL bp_no_dup: out_valid got %b want 0", out_valid); n_fail++; end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(4'(i + 1), 5'd0, 5'd0, 32'h100 + 32'(i), 32'h200 + 32'(i), 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); n_fail++; end
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_alu_op, out_a, out_b} !== {1'b1, 4'(i + 1), 32'h100 + 32'(i), 32'h200 + 32'(i)}) begin
        $display("FAIL b2b_out[%0d]: got v=%b op=%h a=%h b=%h, want 1 %h %h %h", i, out_valid,
                 out_alu_op, out_a, out_b, 4'(i + 1), 32'h100 + 32'(i), 32'h200 + 32'(i));
        n_fail++;
      end
    end
    idle();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin $display("FAIL b2b_drain: out_valid got %b want 0", out_valid); n_fail++; end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(4'd2, 5'd0, 5'd0, 32'h5, 32'h0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    drive(4'd3, 5'd0, 5'd0, 32'h6, 32'h0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    flush = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      $display("FAIL flush_pre: got v=%b rdy=%b, want 1 0", out_valid, in_ready); n_fail++;
    end
    @(negedge clk);
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0) begin $display("FAIL flush_kill: out_valid got %b want 0", out_valid); n_fail++; end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin $display("FAIL flush_no_capture: out_valid got %b want 0", out_valid); n_fail++; end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(4'd7, 5'd0, 5'd0, 32'hAB, 32'h0, 32'hCD, 1'b1, 5'd3, 5'd4, 1'b1);
    @(negedge clk);
    drive(4'd1, 5'd4, 5'd0, 32'h1, 32'h0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    #1;
    n_checks++;
    if ({out_valid, in_ready, out_a, out_b} !== {1'b1, 1'b0, 32'hAB, 32'hCD}) begin
      $display("FAIL rmid_pre: got v=%b rdy=%b a=%h b=%h, want 1 0 ab cd", out_valid, in_ready, out_a, out_b);
      n_fail++;
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_alu_op, out_a, out_b, out_shamt, out_write_reg, out_reg_write} !== 80'd0) begin
      $display("FAIL rmid_outputs: got v=%b op=%h a=%h b=%h sh=%h wr=%h rw=%b, want all 0",
               out_valid, out_alu_op, out_a, out_b, out_shamt, out_write_reg, out_reg_write);
      n_fail++;
    end
    idle();
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL rmid_after: got v=%b rdy=%b, want 0 1", out_valid, in_ready); n_fail++;
    end
  endtask

`ifdef ALU_OPERAND_FORWARDING_EN
  task automatic test_forwarding();
    out_ready = 1'b0;
    drive(4'd4, 5'd8, 5'd0, 32'h0, 32'h77, 32'd0, 1'b0, 5'd0, 5'd1, 1'b1);
    @(negedge clk);
    idle();
    exmem_reg_write = 1'b1; exmem_write_reg = 5'd8; exmem_data = 32'h1234;
    #1;
    n_checks++;
    if (out_a !== 32'h1234) begin $display("FAIL fwd_exmem: out_a got %h want 1234", out_a); n_fail++; end
    memwb_reg_write = 1'b1; memwb_write_reg = 5'd8; memwb_data = 32'hFFFF;
    #1;
    n_checks++;
    if ({out_a, out_b} !== {32'h1234, 32'h77}) begin
      $display("FAIL fwd_priority: got a=%h b=%h want 1234 77", out_a, out_b); n_fail++;
    end
    @(negedge clk);
    exmem_reg_write = 1'b0;
    memwb_data = 32'h1234;
    #1;
    n_checks++;
    if (out_a !== 32'h1234) begin $display("FAIL fwd_memwb: out_a got %h want 1234", out_a); n_fail++; end
    @(negedge clk);
    clear_producers();
    #1;
    n_checks++;
    if ({out_valid, out_a} !== {1'b1, 32'h1234}) begin
      $display("FAIL fwd_stale: got v=%b a=%h want 1 1234", out_valid, out_a); n_fail++;
    end
    // Incoming reader of the held destination is not stalled when forwarding is on.
    out_ready = 1'b1;
    drive(4'd6, 5'd0, 5'd8, 32'h0, 32'h0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    in_rs_addr = 5'd1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin $display("FAIL fwd_no_stall: in_ready got %b want 1", in_ready); n_fail++; end
    @(negedge clk);
    out_ready = 1'b0;
    idle();
    exmem_reg_write = 1'b1; exmem_write_reg = 5'd0; exmem_data = 32'h55;
    in_rs_addr = 5'd0;
    #1;
    n_checks++;
    if (out_a !== 32'h0) begin $display("FAIL fwd_reg0: out_a got %h want 0", out_a); n_fail++; end
    exmem_write_reg = 5'd8;
    #1;
    n_checks++;
    if (out_b !== 32'h55) begin $display("FAIL fwd_rt: out_b got %h want 55", out_b); n_fail++; end
    @(negedge clk);
    clear_producers();
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin $display("FAIL fwd_drain: out_valid got %b want 0", out_valid); n_fail++; end
  endtask
`else
  task automatic test_hazard();
    out_ready = 1'b0;
    drive(4'd4, 5'd0, 5'd0, 32'h1, 32'h0, 32'd0, 1'b0, 5'd0, 5'd9, 1'b1);
    @(negedge clk);
    drive(4'd6, 5'd9, 5'd0, 32'h99, 32'h0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin $display("FAIL haz_held: in_ready got %b want 0", in_ready); n_fail++; end
    @(negedge clk);
    exmem_reg_write = 1'b1; exmem_write_reg = 5'd9;
    #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b00) begin
      $display("FAIL haz_exmem: got rdy=%b v=%b want 0 0", in_ready, out_valid); n_fail++;
    end
    @(negedge clk);
    exmem_reg_write = 1'b0;
    memwb_reg_write = 1'b1; memwb_write_reg = 5'd9;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin $display("FAIL haz_memwb: in_ready got %b want 0", in_ready); n_fail++; end
    @(negedge clk);
    clear_producers();
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin $display("FAIL haz_clear: in_ready got %b want 1", in_ready); n_fail++; end
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_alu_op, out_a} !== {1'b1, 4'd6, 32'h99}) begin
      $display("FAIL haz_capture: got v=%b op=%h a=%h want 1 6 99", out_valid, out_alu_op, out_a); n_fail++;
    end
    exmem_reg_write = 1'b1; exmem_write_reg = 5'd5;
    drive(4'd2, 5'd0, 5'd5, 32'h0, 32'h0, 32'h3, 1'b1, 5'd0, 5'd0, 1'b0);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin $display("FAIL haz_rt_imm: in_ready got %b want 1", in_ready); n_fail++; end
    in_alu_src = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin $display("FAIL haz_rt_reg: in_ready got %b want 0", in_ready); n_fail++; end
    exmem_write_reg = 5'd0; in_rt_addr = 5'd0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin $display("FAIL haz_reg0: in_ready got %b want 1", in_ready); n_fail++; end
    idle();
    clear_producers();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin $display("FAIL haz_drain: out_valid got %b want 0", out_valid); n_fail++; end
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_backpressure();
    test_back_to_back();
`ifdef ALU_OPERAND_FORWARDING_EN
    test_forwarding();
`else
    test_hazard();
`endif
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
